// File: rtl/ifu_fetch_stage_if.sv
// Fetch-stage bus bundle: redirect input, I-cache request/response, decode hand-off.
interface ifu_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ifu_r_valid;
    logic [ADDR_W-1:0] ifu_r_addr;
    logic              ifu_r_ready;
    logic [DATA_W-1:0] ifu_r_data;
    logic              idu_valid;
    logic [ADDR_W-1:0] idu_pc;
    logic [DATA_W-1:0] idu_inst;
    logic              idu_ready;

    // Fetch stage side
    modport master (
        input  redirect_valid, redirect_pc, ifu_r_ready, ifu_r_data, idu_ready,
        output ifu_r_valid, ifu_r_addr, idu_valid, idu_pc, idu_inst
    );

    // Environment side: redirect source, I-cache and decode
    modport slave (
        output redirect_valid, redirect_pc, ifu_r_ready, ifu_r_data, idu_ready,
        input  ifu_r_valid, ifu_r_addr, idu_valid, idu_pc, idu_inst
    );
endinterface

// File: rtl/ifu_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one I-cache request at a time,
// buffers the returned instruction for decode and absorbs redirects.
//
// state | meaning
// ------+------------------------------------------------------------------
// GAP   | idle cycle between requests; next cycle requests pc
// REQ   | request to I-cache outstanding at fetch_addr
// DROP  | request outstanding but squashed by a redirect; data will be discarded
// OUT   | instruction held in inst_buf, offered to decode
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic                clock,
    input  logic                reset,
    ifu_fetch_stage_if.master   bus
);
    typedef enum logic [1:0] {GAP, REQ, DROP, OUT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
    logic [DATA_W-1:0] inst_buf, inst_buf_nxt;
    logic [ADDR_W-1:0] redirect_target;

    // Redirect targets are word aligned; low two bits are dropped.
    assign redirect_target = bus.redirect_pc & ~ADDR_W'(3);

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= GAP;
            pc         <= ADDR_W'(RESET_PC);
            fetch_addr <= ADDR_W'(RESET_PC);
            inst_buf   <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fetch_addr <= fetch_addr_nxt;
            inst_buf   <= inst_buf_nxt;
        end
    end

    // Next-state and datapath update; fetch_addr latches the updated pc on every entry to REQ.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_buf_nxt = inst_buf;
        unique case (state)
            GAP: begin
                if (bus.redirect_valid) pc_nxt = redirect_target;
                state_nxt = REQ;
            end
            REQ: begin
                if (bus.redirect_valid) pc_nxt = redirect_target;
                if (bus.ifu_r_ready) begin
                    if (bus.redirect_valid) begin
                        state_nxt = GAP;
                    end else begin
                        inst_buf_nxt = bus.ifu_r_data;
                        state_nxt    = OUT;
                    end
                end else if (bus.redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                // The cache has committed; keep requesting until it answers, then discard.
                if (bus.redirect_valid) pc_nxt = redirect_target;
                if (bus.ifu_r_ready) state_nxt = GAP;
            end
            OUT: begin
                // A redirect squashes the buffered instruction even if decode is taking it.
                if (bus.redirect_valid) begin
                    pc_nxt    = redirect_target;
                    state_nxt = REQ;
                end else if (bus.idu_ready) begin
                    pc_nxt    = fetch_addr + ADDR_W'(4);
                    state_nxt = REQ;
                end
            end
            default: state_nxt = GAP;
        endcase
        fetch_addr_nxt = (state_nxt == REQ && state != REQ) ? pc_nxt : fetch_addr;
    end

    // Outputs come straight from registered state.
    always_comb begin
        bus.ifu_r_valid = (state == REQ) || (state == DROP);
        bus.ifu_r_addr  = fetch_addr;
        bus.idu_valid   = (state == OUT);
        bus.idu_pc      = fetch_addr;
        bus.idu_inst    = inst_buf;
    end
endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed bench for the fetch stage: reset, fetch/accept, decode stall,
// redirects in REQ/DROP/OUT, PC wrap and reset mid-fetch.
module tb_ifu_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ifu_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ifu_fetch_stage #(.RESET_PC(RST_PC), .ADDR_W(32), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr);
        check({tag, "_rvalid"}, {31'd0, bus.ifu_r_valid}, 32'd1);
        check({tag, "_raddr"},  bus.ifu_r_addr, addr);
        check({tag, "_ivalid"}, {31'd0, bus.idu_valid}, 32'd0);
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_rvalid"}, {31'd0, bus.ifu_r_valid}, 32'd0);
        check({tag, "_ivalid"}, {31'd0, bus.idu_valid}, 32'd1);
        check({tag, "_ipc"},    bus.idu_pc, pc);
        check({tag, "_iinst"},  bus.idu_inst, inst);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rvalid"}, {31'd0, bus.ifu_r_valid}, 32'd0);
        check({tag, "_ivalid"}, {31'd0, bus.idu_valid}, 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check_idle(tag);
        check({tag, "_raddr"}, bus.ifu_r_addr, RST_PC);
        check({tag, "_ipc"},   bus.idu_pc, RST_PC);
        check({tag, "_iinst"}, bus.idu_inst, 32'd0);
    endtask

    // Single cycle response strobe from the cache.
    task automatic respond(input logic [31:0] data);
        bus.ifu_r_ready = 1'b1;
        bus.ifu_r_data  = data;
        tick();
        bus.ifu_r_ready = 1'b0;
        bus.ifu_r_data  = 32'd0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.ifu_r_ready    = 1'b0;
        bus.ifu_r_data     = 32'd0;
        bus.idu_ready      = 1'b0;

        // Reset values
        tick();
        tick();
        check_reset("rst");
        reset = 1'b0;

        // 1: first fetch, cache answers one cycle after valid
        tick();
        check_req("t1_req", 32'h3000_0000);
        tick();
        check_req("t1_hold", 32'h3000_0000);
        respond(32'h0000_0013);
        check_out("t1_out", 32'h3000_0000, 32'h0000_0013);

        // 2: decode stalls five cycles, then accepts
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("t2_stall", 32'h3000_0000, 32'h0000_0013);
        end
        bus.idu_ready = 1'b1;
        tick();
        bus.idu_ready = 1'b0;
        check_req("t2_next", 32'h3000_0004);

        // 3: redirect while the cache stalls ten cycles
        redirect(32'h3000_0100);
        check_req("t3_drop", 32'h3000_0004);
        for (int i = 0; i < 9; i++) begin
            tick();
            check_req("t3_stall", 32'h3000_0004);
        end
        respond(32'hDEAD_BEEF);
        check_idle("t3_gap");
        tick();
        check_req("t3_req", 32'h3000_0100);

        // 4: two redirects, the later one made while in DROP
        redirect(32'h3000_0200);
        check_req("t4_drop", 32'h3000_0100);
        redirect(32'h3000_0300);
        check_req("t4_drop2", 32'h3000_0100);
        respond(32'h1234_5678);
        check_idle("t4_gap");
        tick();
        check_req("t4_req", 32'h3000_0300);

        // 5: redirect and decode accept together; redirect wins
        respond(32'h0010_0093);
        check_out("t5_out", 32'h3000_0300, 32'h0010_0093);
        bus.idu_ready = 1'b1;
        redirect(32'h3000_0040);
        bus.idu_ready = 1'b0;
        check_req("t5_redir", 32'h3000_0040);
        respond(32'h0020_0113);
        check_out("t5_out2", 32'h3000_0040, 32'h0020_0113);
        redirect(32'h3000_0043);
        check_req("t5_align", 32'h3000_0040);

        // 6: redirect with same-cycle response, then PC wrap, then reset mid-fetch
        bus.ifu_r_ready = 1'b1;
        bus.ifu_r_data  = 32'h5555_5555;
        redirect(32'hFFFF_FFFC);
        bus.ifu_r_ready = 1'b0;
        bus.ifu_r_data  = 32'd0;
        check_idle("t6_gap");
        tick();
        check_req("t6_req", 32'hFFFF_FFFC);
        respond(32'h1111_1111);
        check_out("t6_out", 32'hFFFF_FFFC, 32'h1111_1111);
        bus.idu_ready = 1'b1;
        tick();
        bus.idu_ready = 1'b0;
        check_req("t6_wrap", 32'h0000_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset("t6_rst");
        bus.ifu_r_ready = 1'b1;
        bus.ifu_r_data  = 32'h2222_2222;
        tick();
        bus.ifu_r_ready = 1'b0;
        bus.ifu_r_data  = 32'd0;
        check_req("t6_late", RST_PC);
        tick();
        check_req("t6_after", RST_PC);
        check("t6_inst", bus.idu_inst, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
